// File: rtl/data_sram_responder.sv
// Slave-side data memory for the memory stage: single-port SRAM responder with
// sub-word lane alignment, post-reset zero-fill sweep and sticky fault capture.
module data_sram_responder #(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        enable,
    input  logic        write_enable,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busy,
    input  logic        err_clear,
    output logic        err_sticky,
    output logic [1:0]  err_kind,
    output logic [31:0] err_addr
);

    localparam int unsigned        IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0]        SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [IDX_W-1:0]   IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);

    localparam logic [1:0] KIND_MISALIGNED = 2'b01;
    localparam logic [1:0] KIND_RANGE      = 2'b10;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Byte lanes touched by an access once shifted into word position; bits
    // [7:4] set means the access spills past the word boundary.
    function automatic logic [7:0] lane_mask_f(input logic [3:0] be, input logic [1:0] off);
        logic [7:0] mask;
        mask = {4'b0000, be} << off;
        return mask;
    endfunction

    function automatic logic [31:0] load_format_f(input logic [31:0] word,
                                                  input logic [1:0]  off,
                                                  input logic [3:0]  be);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {off, 3'b000};
        result  = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = shifted[8*i +: 8];
            end else begin
                result[8*i +: 8] = 8'h00;
            end
        end
        return result;
    endfunction

    logic [31:0]      mem_r [DEPTH_WORDS];
    state_t           state_r, state_s;
    logic [IDX_W-1:0] clear_idx_r, clear_idx_s;
    logic             err_sticky_r;
    logic [1:0]       err_kind_r;
    logic [31:0]      err_addr_r;

    logic [1:0]       offset_s;
    logic [31:0]      rel_addr_s;
    logic             in_range_s;
    logic [IDX_W-1:0] index_s;
    logic [7:0]       lane_mask_s;
    logic             misaligned_s;
    logic             ready_s;
    logic             clearing_s;
    logic             access_ok_s;
    logic             store_s;
    logic             fault_s;
    logic [1:0]       fault_kind_s;
    logic [31:0]      wdata_lane_s;

    // Address decode and access classification for the current cycle.
    always_comb begin
        offset_s     = address[1:0];
        rel_addr_s   = address - BASE_ADDR;
        in_range_s   = ({1'b0, rel_addr_s} < SPAN_BYTES);
        index_s      = rel_addr_s[IDX_W+1:2];
        lane_mask_s  = lane_mask_f(byte_enable, offset_s);
        misaligned_s = |lane_mask_s[7:4];
        wdata_lane_s = write_data << {offset_s, 3'b000};
        ready_s      = (state_r == ST_READY) && !rst;
        clearing_s   = (state_r == ST_CLEAR) && !rst;
        access_ok_s  = ready_s && enable && in_range_s && !misaligned_s;
        store_s      = access_ok_s && write_enable;
        fault_s      = ready_s && enable && (!in_range_s || misaligned_s);
        // Out-of-range outranks misalignment when both apply.
        if (!in_range_s) begin
            fault_kind_s = KIND_RANGE;
        end else begin
            fault_kind_s = KIND_MISALIGNED;
        end
    end

    // Read-first load path: reflects the array before this cycle's store.
    always_comb begin
        read_data = 32'h0000_0000;
        if (access_ok_s) begin
            read_data = load_format_f(mem_r[index_s], offset_s, byte_enable);
        end else begin
            read_data = 32'h0000_0000;
        end
    end

    // Clear-sweep sequencing.
    always_comb begin
        state_s     = state_r;
        clear_idx_s = clear_idx_r;
        case (state_r)
            ST_CLEAR: begin
                if (clear_idx_r == LAST_IDX) begin
                    state_s     = ST_READY;
                    clear_idx_s = IDX_ZERO;
                end else begin
                    state_s     = ST_CLEAR;
                    clear_idx_s = clear_idx_r + IDX_ONE;
                end
            end
            ST_READY: begin
                state_s     = ST_READY;
                clear_idx_s = IDX_ZERO;
            end
            default: begin
                state_s     = ST_READY;
                clear_idx_s = IDX_ZERO;
            end
        endcase
    end

    // State register; reset restarts the sweep from index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clear_idx_r <= IDX_ZERO;
        end else begin
            state_r     <= state_s;
            clear_idx_r <= clear_idx_s;
        end
    end

    // Array writes: sweep zeroing or lane-masked store; contents survive rst.
    always_ff @(posedge clk) begin
        if (clearing_s) begin
            mem_r[clear_idx_r] <= 32'h0000_0000;
        end else if (store_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask_s[i]) begin
                    mem_r[index_s][8*i +: 8] <= wdata_lane_s[8*i +: 8];
                end
            end
        end
    end

    // Sticky fault capture; a fault in the same cycle as err_clear is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_r <= 1'b0;
            err_kind_r   <= 2'b00;
            err_addr_r   <= 32'h0000_0000;
        end else if (fault_s && (!err_sticky_r || err_clear)) begin
            err_sticky_r <= 1'b1;
            err_kind_r   <= fault_kind_s;
            err_addr_r   <= address;
        end else if (err_clear) begin
            err_sticky_r <= 1'b0;
            err_kind_r   <= 2'b00;
            err_addr_r   <= 32'h0000_0000;
        end
    end

    assign busy       = (state_r == ST_CLEAR);
    assign err_sticky = err_sticky_r;
    assign err_kind   = err_kind_r;
    assign err_addr   = err_addr_r;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised scoreboard bench for data_sram_responder against a byte-addressed
// behavioural model; directed cases cover lane alignment, faults and the sweep.
module tb_data_sram_responder;

    localparam int          D    = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = 32'h0;
    logic        enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [3:0]  byte_enable = 4'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        busy;
    logic        err_clear = 1'b0;
    logic        err_sticky;
    logic [1:0]  err_kind;
    logic [31:0] err_addr;

    data_sram_responder #(.DEPTH_WORDS(D), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .address(address), .enable(enable),
        .write_enable(write_enable), .byte_enable(byte_enable), .write_data(write_data),
        .read_data(read_data), .busy(busy), .err_clear(err_clear),
        .err_sticky(err_sticky), .err_kind(err_kind), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        bit          chk_status;
        logic        busy;
        logic        sticky;
        logic [1:0]  kind;
        logic [31:0] eaddr;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: byte-addressable storage plus error state.
    logic [31:0] m_mem [D];
    int          m_clear_left = 0;
    bit          m_known = 1'b0;
    logic        m_sticky = 1'b0;
    logic [1:0]  m_kind = 2'b00;
    logic [31:0] m_eaddr = 32'h0;

    function automatic logic [7:0] m_get_byte(input longint baddr);
        logic [31:0] w;
        w = m_mem[int'(baddr >> 2)];
        return w[8*int'(baddr % 4) +: 8];
    endfunction

    task automatic m_put_byte(input longint baddr, input logic [7:0] b);
        logic [31:0] w;
        w = m_mem[int'(baddr >> 2)];
        w[8*int'(baddr % 4) +: 8] = b;
        m_mem[int'(baddr >> 2)] = w;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // One clock cycle of stimulus; the expectation reflects state before the edge.
    task automatic step(input bit r, input bit en, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd, input bit ec,
                        input string tag);
        exp_t   e;
        longint a, lo, hi, rel;
        int     off;
        bit     in_range, mis, legal;
        @(posedge clk);
        #1;
        rst = r; enable = en; write_enable = we; byte_enable = be;
        address = addr; write_data = wd; err_clear = ec;

        a   = longint'(addr);
        lo  = longint'(BASE);
        hi  = lo + 4 * D - 1;
        rel = a - lo;
        off = int'(addr % 4);
        in_range = (a >= lo) && (a <= hi);
        // A sub-word access is legal only if its last enabled byte stays in the word.
        mis = 1'b0;
        for (int k = 0; k < 4; k++) if (be[k] && (off + k > 3)) mis = 1'b1;
        legal = in_range && !mis;

        e.rd = 32'h0;
        if (!r && m_clear_left == 0 && en && legal) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) e.rd[8*k +: 8] = m_get_byte(rel + k);
        end
        e.chk_status = m_known;
        e.busy   = (m_clear_left > 0);
        e.sticky = m_sticky;
        e.kind   = m_kind;
        e.eaddr  = m_eaddr;
        e.tag    = tag;
        exp_q.push_back(e);

        if (r) begin
            m_known = 1'b1; m_sticky = 1'b0; m_kind = 2'b00; m_eaddr = 32'h0;
            m_clear_left = D;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
            if (m_clear_left == 0) for (int i = 0; i < D; i++) m_mem[i] = 32'h0;
        end else begin
            if (en && !legal && (!m_sticky || ec)) begin
                m_sticky = 1'b1;
                m_kind   = !in_range ? 2'b10 : 2'b01;
                m_eaddr  = addr;
            end else if (ec) begin
                m_sticky = 1'b0; m_kind = 2'b00; m_eaddr = 32'h0;
            end
            if (en && we && legal)
                for (int k = 0; k < 4; k++)
                    if (be[k]) m_put_byte(rel + k, wd[8*k +: 8]);
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, tag);
    endtask

    task automatic rand_step(input string tag);
        logic [3:0]  be;
        logic [31:0] addr;
        case ($urandom % 5)
            0:       be = 4'b0001;
            1:       be = 4'b0011;
            2, 3:    be = 4'b1111;
            default: be = 4'($urandom);
        endcase
        case ($urandom % 8)
            6:       addr = BASE + $urandom_range(32'hFF0, 32'h100F);
            7:       addr = $urandom;
            default: addr = BASE + $urandom_range(0, 63);
        endcase
        step(1'b0, ($urandom % 4) != 0, 1'($urandom), be, addr, $urandom,
             ($urandom % 16) == 0, tag);
    endtask

    // Scoreboard monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".read_data"}, read_data, e.rd);
            if (e.chk_status) begin
                chk({e.tag, ".busy"},       32'(busy),       32'(e.busy));
                chk({e.tag, ".err_sticky"}, 32'(err_sticky), 32'(e.sticky));
                chk({e.tag, ".err_kind"},   32'(err_kind),   32'(e.kind));
                chk({e.tag, ".err_addr"},   err_addr,        e.eaddr);
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, "rst");
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, "rst_load");
        for (int i = 0; i < D; i++) begin
            if (i == 5)      step(1'b0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hCAFEBABE, 1'b0, "busy_store");
            else if (i == 7) step(1'b0, 1'b1, 1'b0, 4'hF, 32'h2001, 32'h0, 1'b0, "busy_fault");
            else             rand_step("sweep1");
        end
        idle("ready");
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, "lw_after_busy_store");

        step(1'b0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h11223344, 1'b0, "sw10");
        step(1'b0, 1'b1, 1'b1, 4'h1, 32'h12, 32'h000000AA, 1'b0, "sb12");
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, "lw10");
        step(1'b0, 1'b1, 1'b0, 4'h1, 32'h13, 32'h0, 1'b0, "lb13");
        step(1'b0, 1'b1, 1'b0, 4'h3, 32'h12, 32'h0, 1'b0, "lh12");
        step(1'b0, 1'b1, 1'b0, 4'h3, 32'h11, 32'h0, 1'b0, "lh11");
        step(1'b0, 1'b1, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 1'b0, "sw20_readfirst");
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, "lw20");
        step(1'b0, 1'b1, 1'b1, 4'h3, 32'h1B, 32'h0000FFFF, 1'b0, "sh1b_misaligned");
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h18, 32'h0, 1'b0, "lw18_unchanged");
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h5000, 32'h0, 1'b0, "lw5000_no_overwrite");
        idle("err_hold");
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, "err_clear");
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0, "lw1000_range");
        idle("range_seen");
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h2, 32'h0, 1'b1, "fault_with_clear");
        idle("fault_wins");
        step(1'b0, 1'b1, 1'b1, 4'hF, 32'hC, 32'h7, 1'b1, "clear_only");

        step(1'b0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h5A5A5A5A, 1'b0, "sw40_prereset");
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, "rst2");
        for (int i = 0; i < 300; i++) rand_step("sweep2_partial");
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, "rst_mid_sweep");
        for (int i = 0; i < D; i++) rand_step("sweep3");
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, "lw40_zeroed");
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, "lw10_zeroed");

        for (int i = 0; i < 3000; i++) rand_step("random");
        idle("drain");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
